// File: rtl/pe_alu_xbar.sv
// CGRA compute tile: 4x4 operand crossbar -> registered two-operand ALU -> 2:1 output switch, configured by a 13-bit serial chain.
// Latency: ALU result registered (1 clk); crossbar, routes and output switch are combinational. No backpressure.
module pe_alu_xbar #(
    parameter int size = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            config_en,
    input  logic            config_in,
    output logic            config_out,
    input  logic [size-1:0] in0,
    input  logic [size-1:0] in1,
    input  logic [size-1:0] in2,
    output logic [size-1:0] out0,
    output logic [size-1:0] route0,
    output logic [size-1:0] route1
);

    logic [12:0]     cfg_q, cfg_d;
    logic [size-1:0] alu_q, alu_d;

    logic [3:0]      alu_op;
    logic            osel;
    logic [1:0]      xsel0, xsel1, xsel2, xsel3;
    logic [size-1:0] x_in [4];
    logic [size-1:0] alu_a, alu_b;
    logic [4:0]      sh;

    assign alu_op = cfg_q[3:0];
    assign osel   = cfg_q[4];
    assign xsel0  = cfg_q[6:5];
    assign xsel1  = cfg_q[8:7];
    assign xsel2  = cfg_q[10:9];
    assign xsel3  = cfg_q[12:11];

    // Slot 2 is the registered ALU result, so feedback never forms a comb loop.
    assign x_in[0] = in0;
    assign x_in[1] = in1;
    assign x_in[2] = alu_q;
    assign x_in[3] = in2;

    assign alu_a  = x_in[xsel0];
    assign alu_b  = x_in[xsel1];
    assign route0 = x_in[xsel2];
    assign route1 = x_in[xsel3];

    assign out0       = osel ? in2 : alu_q;
    assign config_out = cfg_q[12];
    assign sh         = alu_b[4:0];

    always_comb begin
        cfg_d = cfg_q;
        if (config_en) begin
            cfg_d = {cfg_q[11:0], config_in};
        end
    end

    always_comb begin
        alu_d = '0;
        case (alu_op)
            4'd0:  alu_d = alu_a + alu_b;
            4'd1:  alu_d = alu_a - alu_b;
            4'd2:  alu_d = alu_a * alu_b;
            4'd3:  alu_d = alu_a & alu_b;
            4'd4:  alu_d = alu_a | alu_b;
            4'd5:  alu_d = alu_a ^ alu_b;
            4'd6:  alu_d = alu_a << sh;
            4'd7:  alu_d = alu_a >> sh;
            4'd8:  alu_d = $unsigned($signed(alu_a) >>> sh);
            4'd9:  alu_d[0] = (alu_a == alu_b);
            4'd10: alu_d[0] = ($signed(alu_a) < $signed(alu_b));
            4'd11: alu_d[0] = (alu_a < alu_b);
            4'd12: alu_d = alu_a;
            4'd13: alu_d = alu_b;
            4'd14: alu_d = ($signed(alu_a) < $signed(alu_b)) ? alu_a : alu_b;
            4'd15: alu_d = ($signed(alu_a) > $signed(alu_b)) ? alu_a : alu_b;
            default: alu_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_q <= '0;
            alu_q <= '0;
        end else begin
            cfg_q <= cfg_d;
            alu_q <= alu_d;
        end
    end

endmodule

// File: tb/tb_pe_alu_xbar.sv
// Bench for pe_alu_xbar: directed values plus random vectors checked against a cycle-level reference model.
module tb_pe_alu_xbar;

    logic        clk = 1'b0;
    logic        reset;
    logic        config_en;
    logic        config_in;
    logic        config_out;
    logic [31:0] in0, in1, in2;
    logic [31:0] out0, route0, route1;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference state: config chain contents and the ALU result register.
    logic [12:0] m_cfg;
    logic [31:0] m_alu;

    pe_alu_xbar #(.size(32)) dut (
        .clk(clk), .reset(reset), .config_en(config_en), .config_in(config_in),
        .config_out(config_out), .in0(in0), .in1(in1), .in2(in2),
        .out0(out0), .route0(route0), .route1(route1)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int          sa, sb;
        int unsigned amt;
        sa  = a;
        sb  = b;
        amt = b % 32;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a * b;
            4'd3:  return a & b;
            4'd4:  return a | b;
            4'd5:  return a ^ b;
            4'd6:  return a << amt;
            4'd7:  return a >> amt;
            4'd8:  return sa >>> amt;
            4'd9:  return (a == b) ? 32'd1 : 32'd0;
            4'd10: return (sa < sb) ? 32'd1 : 32'd0;
            4'd11: return (a < b) ? 32'd1 : 32'd0;
            4'd12: return a;
            4'd13: return b;
            4'd14: return (sa < sb) ? a : b;
            default: return (sa > sb) ? a : b;
        endcase
    endfunction

    function automatic logic [31:0] m_out0();
        return m_cfg[4] ? in2 : m_alu;
    endfunction

    function automatic logic [31:0] m_route(input int k);
        logic [31:0] xi [4];
        xi[0] = in0; xi[1] = in1; xi[2] = m_alu; xi[3] = in2;
        return xi[(m_cfg >> (5 + 2 * k)) & 13'd3];
    endfunction

    // Advance one clock, updating the reference model from the inputs held before the edge.
    task automatic tick();
        logic [12:0] ncfg;
        logic [31:0] nalu;
        if (reset) begin
            ncfg = '0;
            nalu = '0;
        end else begin
            nalu = ref_alu(m_cfg[3:0], m_route(0), m_route(1));
            ncfg = config_en ? {m_cfg[11:0], config_in} : m_cfg;
        end
        @(posedge clk);
        #1;
        m_cfg = ncfg;
        m_alu = nalu;
    endtask

    task automatic load_cfg(input logic [12:0] v);
        for (int i = 12; i >= 0; i--) begin
            config_en = 1'b1;
            config_in = v[i];
            tick();
        end
        config_en = 1'b0;
        config_in = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; config_en = 1'b1; config_in = 1'b1;
        in0 = 32'd0; in1 = 32'd0; in2 = 32'd0;
        m_cfg = '0; m_alu = '0;
        tick();
        tests_run++;
        if (config_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_config_out got %b want 0", config_out);
        end
        tests_run++;
        if (out0 !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_out0 got %h want 0", out0);
        end
        reset = 1'b0; config_en = 1'b0; config_in = 1'b0;
        in0 = 32'd5;
        tick();
        tests_run++;
        if (out0 !== 32'd10) begin
            tests_failed++;
            $display("FAIL reset_first_add got %0d want 10", out0);
        end
    endtask

    task automatic test_config_add();
        logic [31:0] r;
        load_cfg(13'h1C80);
        in0 = 32'd7; in1 = 32'd9; r = $urandom; in2 = r;
        tick();
        tests_run++;
        if (out0 !== 32'd16) begin
            tests_failed++;
            $display("FAIL cfg_add got %0d want 16", out0);
        end
        tests_run++;
        if (route0 !== 32'd16) begin
            tests_failed++;
            $display("FAIL cfg_route0 got %h want %h", route0, 32'd16);
        end
        tests_run++;
        if (route1 !== r) begin
            tests_failed++;
            $display("FAIL cfg_route1 got %h want %h", route1, r);
        end
    endtask

    task automatic test_opcodes();
        logic [31:0] va [7];
        logic [31:0] vb [7];
        logic [31:0] ve [7];
        logic [3:0]  vop [7];
        logic [31:0] exp;
        vop[0] = 4'd1;  va[0] = 32'h80000000; vb[0] = 32'h4; ve[0] = 32'h7FFFFFFC;
        vop[1] = 4'd7;  va[1] = 32'h80000000; vb[1] = 32'h4; ve[1] = 32'h08000000;
        vop[2] = 4'd8;  va[2] = 32'h80000000; vb[2] = 32'h4; ve[2] = 32'hF8000000;
        vop[3] = 4'd10; va[3] = 32'h80000000; vb[3] = 32'h4; ve[3] = 32'h1;
        vop[4] = 4'd11; va[4] = 32'h80000000; vb[4] = 32'h4; ve[4] = 32'h0;
        vop[5] = 4'd15; va[5] = 32'h80000000; vb[5] = 32'h4; ve[5] = 32'h4;
        vop[6] = 4'd2;  va[6] = 32'hFFFFFFFF; vb[6] = 32'h2; ve[6] = 32'hFFFFFFFE;
        for (int i = 0; i < 7; i++) begin
            load_cfg(13'h1C80 | 13'(vop[i]));
            in0 = va[i]; in1 = vb[i];
            tick();
            tests_run++;
            if (out0 !== ve[i]) begin
                tests_failed++;
                $display("FAIL op_directed_%0d got %h want %h", vop[i], out0, ve[i]);
            end
        end
        for (int op = 0; op < 16; op++) begin
            load_cfg(13'h1C80 | 13'(op));
            for (int k = 0; k < 6; k++) begin
                in0 = $urandom; in1 = $urandom; in2 = $urandom;
                if (k == 0) in1 = in0;
                if (k == 1) in1 = 32'($urandom_range(0, 40));
                if (k == 2) in0 = in0 | 32'h80000000;
                exp = ref_alu(4'(op), in0, in1);
                tick();
                tests_run++;
                if (out0 !== exp || route0 !== m_alu) begin
                    tests_failed++;
                    $display("FAIL op_rand_%0d out0 %h route0 %h want %h", op, out0, route0, exp);
                end
            end
        end
    endtask

    task automatic test_accumulate();
        reset = 1'b1; in0 = 32'd0; in1 = 32'd0; in2 = 32'd0;
        tick();
        reset = 1'b0;
        load_cfg(13'h0C0);
        in1 = 32'd3;
        for (int i = 1; i <= 4; i++) begin
            tick();
            tests_run++;
            if (out0 !== 32'(3 * i) || out0 !== m_out0()) begin
                tests_failed++;
                $display("FAIL accum_step%0d got %0d want %0d", i, out0, 3 * i);
            end
        end
    endtask

    task automatic test_bypass();
        load_cfg(13'h010);
        in2 = 32'hDEADBEEF; in0 = $urandom; in1 = $urandom;
        #1;
        tests_run++;
        if (out0 !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL bypass_same_cycle got %h want deadbeef", out0);
        end
        for (int i = 0; i < 3; i++) begin
            in0 = $urandom; in1 = $urandom; in2 = $urandom;
            tick();
            tests_run++;
            if (out0 !== in2) begin
                tests_failed++;
                $display("FAIL bypass_rand got %h want %h", out0, in2);
            end
        end
    endtask

    task automatic test_chain();
        logic [25:0] pat;
        logic        held;
        pat = 26'($urandom);
        for (int j = 1; j <= 26; j++) begin
            config_en = 1'b1;
            config_in = pat[26 - j];
            tick();
            if (j >= 13) begin
                tests_run++;
                if (config_out !== pat[25 - (j - 13)] || config_out !== m_cfg[12]) begin
                    tests_failed++;
                    $display("FAIL chain_shift%0d got %b want %b", j, config_out, pat[25 - (j - 13)]);
                end
            end
        end
        config_en = 1'b0;
        held = config_out;
        for (int j = 0; j < 4; j++) begin
            config_in = ~config_in;
            tick();
            tests_run++;
            if (config_out !== pat[12] || config_out !== held) begin
                tests_failed++;
                $display("FAIL chain_hold%0d got %b want %b", j, config_out, pat[12]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_config_add();
        test_opcodes();
        test_accumulate();
        test_bypass();
        test_chain();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
